sequence_datapath: RTL and testbench



---
 rtl/sequence_datapath_pkg.sv | 30 +++
 rtl/sequence_datapath_tick_gen.sv | 36 +++
 rtl/sequence_datapath.sv | 199 +++++++++++++++++++
 tb/tb_sequence_datapath.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_datapath_pkg.sv
// Shared definitions for the memory-sequence game datapath: LFSR geometry and
// step function, symbol/colour encoding, score width and a counter-width helper.
package sequence_datapath_pkg;

  localparam int LFSR_W  = 16;
  localparam int SYM_W   = 2;
  localparam int COLOR_W = 4;
  localparam int SCORE_W = 5;

  // An all-zero Fibonacci LFSR never leaves zero, so zero seeds map to this.
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP_SEED = 16'h0001;

  typedef logic [LFSR_W-1:0]  lfsr_t;
  typedef logic [SYM_W-1:0]   sym_t;
  typedef logic [COLOR_W-1:0] color_t;

  // Taps 16,14,13,11 (bits 15,13,12,10), shifting towards the MSB.
  function automatic lfsr_t lfsr_step(input lfsr_t s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic color_t sym_onehot(input sym_t s);
    return color_t'(4'b0001 << s);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sequence_datapath_tick_gen.sv
// Tick generator shared by LED playback and the user inactivity timer.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   clr_i   - restart the count at 0 (wins over en_i)
//   en_i    - count enable
//   tick_o  - one-cycle pulse on the last cycle of each TICK_DIV period
//   count_o - current position inside the period
module tick_gen
  import sequence_datapath_pkg::*;
#(
  parameter int TICK_DIV = 4,
  localparam int CW = cnt_w(TICK_DIV)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic          tick_o,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q;

  assign tick_o  = en_i && (count_q == CW'(TICK_DIV - 1));
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= tick_o ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/sequence_datapath.sv
// Datapath of the memory-sequence game, driven by the game controller FSM.
// Generates an LFSR colour sequence from a seed, plays it on the LEDs, checks
// the player's presses against it and tracks rounds, score and win.
// Ports:
//   clock_50, reset            - clock, synchronous active-high reset
//   r1, r2                     - game clear / round clear
//   e1, e2, e3, e4             - setup / user play / FPGA play / check enables
//   sel                        - show result (win) on the LEDs
//   sw[15:0], key[3:0]         - seed switches, player buttons (active-high)
//   end_fpga, end_user,
//   end_time, match, win       - status flags (match is combinational)
//   led_out[3:0], score[4:0]   - colour display, completed rounds
module sequence_datapath
  import sequence_datapath_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int N_ROUNDS     = 16,
  parameter int USER_TIMEOUT = 5
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        r1,
  input  logic        r2,
  input  logic        e1,
  input  logic        e2,
  input  logic        e3,
  input  logic        e4,
  input  logic        sel,
  input  logic [15:0] sw,
  input  logic [3:0]  key,
  output logic        end_fpga,
  output logic        end_user,
  output logic        end_time,
  output logic        match,
  output logic        win,
  output logic [3:0]  led_out,
  output logic [4:0]  score
);

  localparam int CW = cnt_w(TICK_DIV);
  localparam int TW = cnt_w(USER_TIMEOUT + 1);

  lfsr_t               seed_q, lfsr_q;
  logic [SCORE_W-1:0]  round_q, score_q, play_idx_q, user_idx_q;
  logic [TW-1:0]       timer_q;
  logic                win_q, err_q, end_fpga_q, end_user_q, end_time_q;
  color_t              led_q;
  logic                e2_q, e3_q, e4_q;
  logic [3:0]          key_q;

  lfsr_t               seed_d, lfsr_adv_d;
  logic                edge2, edge3, edge4;
  logic                mode_fpga, mode_user;
  logic                fpga_run, user_live, user_run;
  logic                press, key_ok, user_press;
  logic                tick, tick_clr, tick_en;
  logic [CW-1:0]       cnt;

  assign seed_d     = (sw == 16'h0000) ? LFSR_LOCKUP_SEED : sw;
  assign lfsr_adv_d = lfsr_step(lfsr_q);

  assign edge2 = e2 & ~e2_q;
  assign edge3 = e3 & ~e3_q;
  assign edge4 = e4 & ~e4_q;

  // Enables are mutually exclusive by priority e1 > e3 > e2 > e4.
  assign mode_fpga = e3 & ~e1;
  assign mode_user = e2 & ~e3 & ~e1;

  assign fpga_run  = mode_fpga & ~edge3 & ~end_fpga_q;
  assign user_live = ~end_user_q & ~end_time_q;
  assign user_run  = mode_user & ~edge2 & user_live;

  // Press = rising edge of "any key"; the pressed pattern must equal the
  // expected one-hot colour exactly, so chords count as wrong.
  assign press      = (|key) & ~(|key_q);
  assign key_ok     = (key == sym_onehot(lfsr_q[1:0]));
  assign user_press = user_run & press;

  // Playback and user timing never overlap, so one counter serves both.
  assign tick_en  = fpga_run | user_run;
  assign tick_clr = r1 | r2 | (mode_fpga & edge3) | (mode_user & edge2) | user_press;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (clock_50),
    .rst_i   (reset),
    .clr_i   (tick_clr),
    .en_i    (tick_en),
    .tick_o  (tick),
    .count_o (cnt)
  );

  always_ff @(posedge clock_50) begin
    if (reset) begin
      seed_q     <= LFSR_LOCKUP_SEED;
      lfsr_q     <= LFSR_LOCKUP_SEED;
      round_q    <= '0;
      score_q    <= '0;
      win_q      <= 1'b0;
      play_idx_q <= '0;
      user_idx_q <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      end_fpga_q <= 1'b0;
      end_user_q <= 1'b0;
      end_time_q <= 1'b0;
      led_q      <= '0;
      e2_q       <= 1'b0;
      e3_q       <= 1'b0;
      e4_q       <= 1'b0;
      key_q      <= '0;
    end else begin
      e2_q  <= e2;
      e3_q  <= e3;
      e4_q  <= e4;
      key_q <= key;
      led_q <= '0;
      if (r1 || r2) begin
        play_idx_q <= '0;
        user_idx_q <= '0;
        timer_q    <= '0;
        err_q      <= 1'b0;
        end_fpga_q <= 1'b0;
        end_user_q <= 1'b0;
        end_time_q <= 1'b0;
        if (r1) begin
          round_q <= '0;
          score_q <= '0;
          win_q   <= 1'b0;
        end
      end else begin
        if (e1) begin
          seed_q <= seed_d;
        end else if (e3) begin
          // The LED register shows the state being entered, so the first
          // colour is visible right after the edge and a new colour appears
          // together with the LFSR step.
          if (edge3) begin
            lfsr_q     <= seed_q;
            play_idx_q <= '0;
            led_q      <= end_fpga_q ? color_t'(0) : sym_onehot(seed_q[1:0]);
          end else if (!end_fpga_q) begin
            if (tick) begin
              lfsr_q <= lfsr_adv_d;
              if (play_idx_q == round_q) begin
                end_fpga_q <= 1'b1;
              end else begin
                play_idx_q <= play_idx_q + 5'd1;
                led_q      <= sym_onehot(lfsr_adv_d[1:0]);
              end
            end else if (int'(cnt) + 1 < TICK_DIV / 2) begin
              led_q <= sym_onehot(lfsr_q[1:0]);
            end
          end
        end else if (e2) begin
          led_q <= key;
          if (edge2) begin
            lfsr_q     <= seed_q;
            user_idx_q <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
          end else if (user_live) begin
            // A press in the timeout cycle takes precedence over the timeout.
            if (press) begin
              if (key_ok) begin
                lfsr_q  <= lfsr_adv_d;
                timer_q <= '0;
                if (user_idx_q == round_q) end_user_q <= 1'b1;
                else                       user_idx_q <= user_idx_q + 5'd1;
              end else begin
                err_q      <= 1'b1;
                end_user_q <= 1'b1;
              end
            end else if (tick) begin
              timer_q <= timer_q + TW'(1);
              if (timer_q == TW'(USER_TIMEOUT - 1)) end_time_q <= 1'b1;
            end
          end
        end else if (e4) begin
          if (edge4 && match && (round_q < 5'(N_ROUNDS))) begin
            round_q <= round_q + 5'd1;
            score_q <= score_q + 5'd1;
            if (round_q == 5'(N_ROUNDS - 1)) win_q <= 1'b1;
          end
        end
        if (sel) led_q <= win_q ? 4'b1111 : 4'b0000;
      end
    end
  end

  assign match    = end_user_q & ~err_q;
  assign end_fpga = end_fpga_q;
  assign end_user = end_user_q;
  assign end_time = end_time_q;
  assign win      = win_q;
  assign led_out  = led_q;
  assign score    = score_q;

endmodule

// File: tb/tb_sequence_datapath.sv
module tb_sequence_datapath;

  localparam int TD = 4;
  localparam int NR = 16;
  localparam int UT = 5;

  logic clk = 1'b0;
  logic reset, r1, r2, e1, e2, e3, e4, sel;
  logic [15:0] sw;
  logic [3:0]  key;
  logic end_fpga, end_user, end_time, match, win;
  logic [3:0] led_out;
  logic [4:0] score;

  sequence_datapath #(.TICK_DIV(TD), .N_ROUNDS(NR), .USER_TIMEOUT(UT)) dut (
    .clock_50(clk), .reset(reset), .r1(r1), .r2(r2), .e1(e1), .e2(e2), .e3(e3),
    .e4(e4), .sel(sel), .sw(sw), .key(key), .end_fpga(end_fpga),
    .end_user(end_user), .end_time(end_time), .match(match), .win(win),
    .led_out(led_out), .score(score)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Reference model state
  logic [15:0] m_seed;
  int          m_round, m_score;
  bit          m_win;
  int          since, idx;
  bit          err;
  logic [3:0]  kprev, klast;

  // Expected DUT outputs after the most recent clock edge
  logic [3:0] x_led;
  logic       x_ef, x_eu, x_et, x_match, x_win;
  logic [4:0] x_score;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("led_out",  led_out,  x_led);
      cmp("end_fpga", end_fpga, x_ef);
      cmp("end_user", end_user, x_eu);
      cmp("end_time", end_time, x_et);
      cmp("match",    match,    x_match);
      cmp("win",      win,      x_win);
      cmp("score",    score,    x_score);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] m_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return (s << 1) | {15'd0, fb};
  endfunction

  function automatic logic [1:0] sym_at(input logic [15:0] seed, input int n);
    logic [15:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = m_next(s);
    return s[1:0];
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] s);
    logic [3:0] r;
    r = 4'b0000;
    r[s] = 1'b1;
    return r;
  endfunction

  task automatic step();
    kprev = klast;
    @(posedge clk);
    klast = key;
    #1;
  endtask

  task automatic do_reset();
    reset = 1; r1 = 0; r2 = 0; e1 = 0; e2 = 0; e3 = 0; e4 = 0; sel = 0;
    key = 0; sw = 0;
    step();
    m_seed = 16'h0001; m_round = 0; m_score = 0; m_win = 0; err = 0;
    x_led = 0; x_ef = 0; x_eu = 0; x_et = 0; x_match = 0; x_win = 0; x_score = 0;
    reset = 0;
  endtask

  task automatic pulse_clr(input bit full);
    if (full) r1 = 1; else r2 = 1;
    step();
    r1 = 0; r2 = 0;
    x_led = 0; x_ef = 0; x_eu = 0; x_et = 0; err = 0; x_match = 0;
    if (full) begin
      m_round = 0; m_score = 0; m_win = 0; x_win = 0; x_score = 0;
    end
  endtask

  task automatic setup(input logic [15:0] s);
    e1 = 1; sw = s;
    step();
    m_seed = (s == 16'h0000) ? 16'h0001 : s;
    x_led = 0;
    e1 = 0; sw = 16'($urandom);
  endtask

  // Playback: t cycles after the edge shows symbol t/TD during the first half
  // of each tick period; end_fpga rises after (round+1)*TD cycles.
  task automatic fpga_play(input int abort_t, input logic [3:0] lit0);
    int len;
    len = (m_round + 1) * TD;
    e3 = 1;
    for (int t = 0; t <= len; t++) begin
      step();
      if (t < len) begin
        x_ef  = 0;
        x_led = ((t % TD) < TD / 2) ? oh(sym_at(m_seed, t / TD)) : 4'b0000;
      end else begin
        x_ef  = 1;
        x_led = 0;
      end
      if (t == 0 && lit0 != 4'b0000) cmp("first_symbol", led_out, lit0);
      if (t == len - 1) cmp("fpga_not_yet_done", end_fpga, 0);
      if (t == len)     cmp("fpga_done_on_time", end_fpga, 1);
      if (t == abort_t) return;
    end
    e3 = 0;
    step();
    x_led = 0;
  endtask

  task automatic user_start();
    e2 = 1; key = 0;
    step();
    x_led = 0; since = 0; idx = 0; err = 0;
    x_match = x_eu & ~err;
  endtask

  task automatic user_cycle(input logic [3:0] k);
    key = k;
    step();
    x_led = k;
    if (!x_eu && !x_et) begin
      since++;
      if (k != 0 && kprev == 0) begin
        if (k == oh(sym_at(m_seed, idx))) begin
          since = 0;
          if (idx == m_round) x_eu = 1;
          else idx++;
        end else begin
          err = 1; x_eu = 1;
        end
      end else if (since == TD * UT) begin
        x_et = 1;
      end
    end
    x_match = x_eu & ~err;
  endtask

  task automatic user_end();
    e2 = 0; key = 0;
    step();
    x_led = 0;
  endtask

  task automatic user_round(input bit wrong, input int maxgap);
    logic [3:0] k, good;
    user_start();
    for (int i = 0; i <= m_round; i++) begin
      repeat ($urandom_range(maxgap, 0)) user_cycle(4'b0000);
      good = oh(sym_at(m_seed, i));
      k = good;
      if (wrong && i == m_round) begin
        k = 4'($urandom_range(15, 1));
        while (k == good) k = 4'($urandom_range(15, 1));
      end
      repeat ($urandom_range(2, 1)) user_cycle(k);
      user_cycle(4'b0000);
    end
    user_end();
  endtask

  task automatic check_e4(input int hold);
    e4 = 1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (i == 0 && x_match && m_round < NR) begin
        m_round++; m_score++;
        if (m_round == NR) m_win = 1;
      end
      x_score = 5'(m_score); x_win = m_win; x_led = 0;
    end
    e4 = 0;
    step();
    x_led = 0;
  endtask

  initial begin
    klast = 0; kprev = 0;
    do_reset();
    chk_on = 1;
    cmp("reset_led", led_out, 0);
    cmp("reset_score", score, 0);

    // Pin the reference sequence to hand-computed values
    cmp("pin_next_ace1", m_next(16'hACE1), 16'h59C3);
    cmp("pin_sym_s1_0", oh(sym_at(16'h0001, 0)), 4'b0010);
    cmp("pin_sym_s1_1", oh(sym_at(16'h0001, 1)), 4'b0100);
    cmp("pin_sym_ace1_1", oh(sym_at(16'hACE1, 1)), 4'b1000);

    // Zero seed falls back to 0x0001
    setup(16'h0000);
    pulse_clr(0);
    fpga_play(-1, 4'b0010);

    // Correct round, then two-symbol playback
    setup(16'hACE1);
    pulse_clr(0);
    user_round(0, 3);
    cmp("match_correct", match, 1);
    check_e4(1);
    cmp("score_one", score, 1);
    pulse_clr(0);
    fpga_play(-1, 4'b0010);

    // Chord press is wrong
    pulse_clr(0);
    user_start();
    user_cycle(4'b0011);
    user_cycle(4'b0000);
    user_end();
    cmp("chord_match", match, 0);
    cmp("chord_end_user", end_user, 1);
    check_e4(3);
    cmp("chord_score", score, 1);

    // Timeout with no press
    pulse_clr(0);
    user_start();
    for (int i = 1; i <= 25; i++) begin
      user_cycle(4'b0000);
      if (i == 19) cmp("timeout_early", end_time, 0);
      if (i == 20) cmp("timeout_at_20", end_time, 1);
    end
    user_end();
    cmp("timeout_end_user", end_user, 0);

    // Press in the timeout cycle wins
    pulse_clr(0);
    user_start();
    repeat (19) user_cycle(4'b0000);
    user_cycle(oh(sym_at(m_seed, 0)));
    cmp("press_beats_timeout", end_time, 0);
    user_cycle(4'b0000);
    user_cycle(oh(sym_at(m_seed, 1)));
    user_cycle(4'b0000);
    user_end();
    cmp("late_round_match", match, 1);

    // Randomised full game to the win
    pulse_clr(1);
    setup(16'($urandom));
    for (int a = 0; a < 200 && !m_win; a++) begin
      pulse_clr(0);
      fpga_play(-1, 4'b0000);
      pulse_clr(0);
      user_round($urandom_range(4, 0) == 0, 6);
      check_e4($urandom_range(3, 1));
    end
    cmp("win_reached", win, 1);
    cmp("win_score", score, 16);
    check_e4(2);
    check_e4(1);
    cmp("score_saturates", score, 16);
    sel = 1;
    step();
    x_led = x_win ? 4'b1111 : 4'b0000;
    cmp("sel_led", led_out, 4'b1111);
    sel = 0;
    step();
    x_led = 0;
    pulse_clr(1);
    cmp("r1_win", win, 0);
    cmp("r1_score", score, 0);

    // Reset in the middle of playback
    setup(16'($urandom));
    for (int r = 0; r < 3; r++) begin
      pulse_clr(0);
      user_round(0, 3);
      check_e4(1);
    end
    pulse_clr(0);
    fpga_play(2 * TD + 1, 4'b0000);
    do_reset();
    cmp("midrst_led", led_out, 0);
    cmp("midrst_fpga", end_fpga, 0);
    cmp("midrst_score", score, 0);
    repeat (3) step();
    fpga_play(-1, 4'b0010);
    pulse_clr(0);
    user_round(0, 2);
    check_e4(10);
    cmp("held_e4_once", score, 1);

    repeat (2) step();
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
